// File: rtl/nios2_vjtag_pkg.sv
// Shared types and constants for the Nios II virtual-JTAG scan master.
// Holds the scan state enum, default widths, IR encodings and the state-to-strobe decode.
package nios2_vjtag_pkg;

  localparam int SR_WIDTH_DEF = 38;
  localparam int IR_WIDTH_DEF = 2;

  localparam logic [IR_WIDTH_DEF-1:0] IR_OCIMEM = 2'd0;
  localparam logic [IR_WIDTH_DEF-1:0] IR_TRACE  = 2'd1;
  localparam logic [IR_WIDTH_DEF-1:0] IR_BREAK  = 2'd2;
  localparam logic [IR_WIDTH_DEF-1:0] IR_ENABLE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI
  } state_t;

  typedef struct packed {
    logic uir;
    logic cdr;
    logic sdr;
    logic udr;
    logic rti;
  } strobe_t;

  // RTI doubles as the idle indication, so IDLE and RTI share the rti strobe.
  function automatic strobe_t state_strobes(state_t s);
    strobe_t st;
    st = '0;
    case (s)
      ST_UIR:          st.uir = 1'b1;
      ST_CDR:          st.cdr = 1'b1;
      ST_SDR:          st.sdr = 1'b1;
      ST_UDR:          st.udr = 1'b1;
      ST_IDLE, ST_RTI: st.rti = 1'b1;
      default:         st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/nios2_vjtag_tck_gen.sv
// TCK generator: toggles tck every TCK_DIV clk while en is high, held at 0 with divider cleared otherwise.
// Latency: rise_en/fall_en are same-cycle pulses for the toggle taking effect at the next clk edge.
// Backpressure: none; fall_next flags the cycle immediately before a fall event.
module nios2_vjtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic rise_en,
  output logic fall_en,
  output logic fall_next
);

  localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          half_done;

  assign half_done = en && (div_cnt == DW'(TCK_DIV - 1));
  assign rise_en   = half_done && !tck;
  assign fall_en   = half_done && tck;

  generate
    if (TCK_DIV == 1) begin : g_div1
      // Every cycle toggles, so the rise cycle is the one right before the fall.
      assign fall_next = en && !tck;
    end else begin : g_divn
      assign fall_next = en && tck && (div_cnt == DW'(TCK_DIV - 2));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (half_done) begin
      div_cnt <= '0;
      tck     <= !tck;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/nios2_vjtag_scan_master.sv
// Virtual-JTAG scan initiator: one IR/DR command -> UIR,CDR,SDR x SR_WIDTH,UDR,RTI with TDO captured into rsp_dr.
// Latency: 2*TCK_DIV*(SR_WIDTH+4) clk accept-to-rsp_valid; SR_WIDTH+3 periods on IR hit with NIOS2_VJTAG_IR_CACHE_EN.
// Backpressure: cmd_ready low while scanning except the last RTI cycle; rsp_valid is a one-clk pulse with no ready.
module nios2_vjtag_scan_master
  import nios2_vjtag_pkg::*;
#(
  parameter int SR_WIDTH = SR_WIDTH_DEF,
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [SR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BW = $clog2(SR_WIDTH);

  state_t              state_q, state_d;
  strobe_t             strb;
  logic [SR_WIDTH-1:0] shift_q;
  logic [SR_WIDTH-1:0] rsp_dr_q;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic [IR_WIDTH-1:0] ir_out_cap_q;
  logic [IR_WIDTH-1:0] rsp_ir_q;
  logic [BW-1:0]       bit_cnt_q;
  logic                tdi_q;
  logic                rsp_vld_q;
  logic                rise_en, fall_en, fall_next;
  logic                accept, skip_uir, last_bit, rsp_load;

  nios2_vjtag_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (busy),
    .tck       (vji_tck),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .fall_next (fall_next)
  );

  assign accept   = cmd_valid && cmd_ready;
  assign last_bit = (bit_cnt_q == BW'(SR_WIDTH - 1));
  // Response registers load one clk early so rsp_valid lines up with the RTI fall event.
  assign rsp_load = (state_q == ST_RTI) && fall_next;

`ifdef NIOS2_VJTAG_IR_CACHE_EN
  logic [IR_WIDTH-1:0] ir_cache_q;
  logic                ir_cache_vld_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_cache_q     <= '0;
      ir_cache_vld_q <= 1'b0;
    end else if (accept) begin
      ir_cache_q     <= cmd_ir;
      ir_cache_vld_q <= 1'b1;
    end
  end

  assign skip_uir = ir_cache_vld_q && (ir_cache_q == cmd_ir);
`else
  assign skip_uir = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = skip_uir ? ST_CDR : ST_UIR;
      ST_UIR:  if (fall_en) state_d = ST_CDR;
      ST_CDR:  if (fall_en) state_d = ST_SDR;
      ST_SDR:  if (fall_en && last_bit) state_d = ST_UDR;
      ST_UDR:  if (fall_en) state_d = ST_RTI;
      // The closing RTI cycle can hand straight over to the next scan.
      ST_RTI: begin
        if (fall_en) begin
          if (accept) state_d = skip_uir ? ST_CDR : ST_UIR;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    strb      = state_strobes(state_q);
    vji_uir   = strb.uir;
    vji_cdr   = strb.cdr;
    vji_sdr   = strb.sdr;
    vji_udr   = strb.udr;
    vji_rti   = strb.rti;
    busy      = (state_q != ST_IDLE);
    cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_RTI) && fall_en);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q      <= '0;
      ir_in_q      <= '0;
      ir_out_cap_q <= '0;
      bit_cnt_q    <= '0;
      tdi_q        <= 1'b0;
    end else begin
      if (accept) begin
        ir_in_q <= cmd_ir;
        shift_q <= cmd_dr;
      end else if ((state_q == ST_SDR) && rise_en) begin
        shift_q <= {vji_tdo, shift_q[SR_WIDTH-1:1]};
      end

      if ((state_q == ST_CDR) && rise_en) ir_out_cap_q <= vji_ir_out;

      if ((state_q == ST_CDR) && fall_en) begin
        bit_cnt_q <= '0;
      end else if ((state_q == ST_SDR) && fall_en && !last_bit) begin
        bit_cnt_q <= bit_cnt_q + BW'(1);
      end

      // TDI moves only on falls; shift_q[0] already holds the next bit after the preceding rise.
      if (fall_en) begin
        if (state_q == ST_CDR)                   tdi_q <= shift_q[0];
        else if ((state_q == ST_SDR) && !last_bit) tdi_q <= shift_q[0];
        else                                     tdi_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_vld_q <= 1'b0;
      rsp_dr_q  <= '0;
      rsp_ir_q  <= '0;
    end else begin
      rsp_vld_q <= rsp_load;
      if (rsp_load) begin
        rsp_dr_q <= shift_q;
        rsp_ir_q <= ir_out_cap_q;
      end
    end
  end

  assign vji_tdi    = tdi_q;
  assign vji_ir_in  = ir_in_q;
  assign rsp_valid  = rsp_vld_q;
  assign rsp_dr     = rsp_dr_q;
  assign rsp_ir_out = rsp_ir_q;

endmodule
